// File: rtl/color_match_judge.sv
// Game-round controller: advances the color randomizer, snapshots its outputs,
// judges ball landings against the platform colors, and tracks score and lives.
module color_match_judge #(
  parameter int SETTLE_CYCLES = 3,
  parameter int HOLD_CYCLES   = 25_000_000,
  parameter int LIVES_INIT    = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  new_color_ball,
  input  logic [11:0] new_color_plats,
  input  logic        land_valid,
  input  logic [1:0]  land_section,
  output logic        color_advance,
  output logic [2:0]  ball_color,
  output logic [11:0] plat_colors,
  output logic        hit,
  output logic        miss,
  output logic [7:0]  score,
  output logic [1:0]  lives,
  output logic        playing,
  output logic        game_over
);

  localparam int CMAX = (SETTLE_CYCLES > HOLD_CYCLES) ? SETTLE_CYCLES : HOLD_CYCLES;
  localparam int CW   = $clog2(CMAX + 1);
  localparam logic [CW-1:0] SETTLE_END = CW'(SETTLE_CYCLES);
  localparam logic [CW-1:0] HOLD_END   = CW'(HOLD_CYCLES - 1);
  localparam logic [1:0]    LIVES0     = 2'(LIVES_INIT);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_PLAY, S_RESULT, S_OVER} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            adv_q, adv_d;
  logic            hit_q, hit_d;
  logic            miss_q, miss_d;
  logic [2:0]      ball_q, ball_d;
  logic [3:0][2:0] plats_q, plats_d;
  logic [7:0]      score_q, score_d;
  logic [1:0]      lives_q, lives_d;

  // A round is only playable if the ball has a real color and some section shows it.
  function automatic logic has_match(input logic [2:0] b, input logic [3:0][2:0] p);
    logic m;
    m = 1'b0;
    for (int k = 0; k < 4; k++) if (p[k] == b) m = 1'b1;
    return m && (b != 3'd0);
  endfunction

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    adv_d   = 1'b0;
    hit_d   = 1'b0;
    miss_d  = 1'b0;
    ball_d  = ball_q;
    plats_d = plats_q;
    score_d = score_q;
    lives_d = lives_q;
    case (state_q)
      S_IDLE, S_OVER: begin
        if (start) begin
          state_d = S_LOAD;
          cnt_d   = '0;
          adv_d   = 1'b1;
          score_d = 8'd0;
          lives_d = LIVES0;
        end
      end
      S_LOAD: begin
        if (cnt_q == SETTLE_END) begin
          ball_d  = new_color_ball;
          plats_d = new_color_plats;
          cnt_d   = '0;
          if (has_match(new_color_ball, new_color_plats)) state_d = S_PLAY;
          else adv_d = 1'b1;  // stay in LOAD and pull a fresh color set
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_PLAY: begin
        if (land_valid) begin
          state_d = S_RESULT;
          cnt_d   = '0;
          if (plats_q[land_section] == ball_q) begin
            hit_d   = 1'b1;
            score_d = (score_q == 8'hff) ? score_q : score_q + 8'd1;
          end else begin
            miss_d  = 1'b1;
            lives_d = (lives_q == 2'd0) ? 2'd0 : lives_q - 2'd1;
          end
        end
      end
      S_RESULT: begin
        if (cnt_q == HOLD_END) begin
          cnt_d = '0;
          if (lives_q == 2'd0) begin
            state_d = S_OVER;
          end else begin
            state_d = S_LOAD;
            adv_d   = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      adv_q   <= 1'b0;
      hit_q   <= 1'b0;
      miss_q  <= 1'b0;
      ball_q  <= 3'd0;
      plats_q <= '0;
      score_q <= 8'd0;
      lives_q <= LIVES0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      adv_q   <= adv_d;
      hit_q   <= hit_d;
      miss_q  <= miss_d;
      ball_q  <= ball_d;
      plats_q <= plats_d;
      score_q <= score_d;
      lives_q <= lives_d;
    end
  end

  assign color_advance = adv_q;
  assign ball_color    = ball_q;
  assign plat_colors   = plats_q;
  assign hit           = hit_q;
  assign miss          = miss_q;
  assign score         = score_q;
  assign lives         = lives_q;
  assign playing       = (state_q == S_PLAY);
  assign game_over     = (state_q == S_OVER);

endmodule

// File: tb/tb_color_match_judge.sv
// Directed bench for color_match_judge: round table plus hand-written reset,
// reload and saturation sequences. Inputs driven and outputs sampled on negedge.
module tb_color_match_judge;

  localparam int SETTLE = 3;
  localparam int HOLD   = 4;

  logic        clk = 1'b0;
  logic        reset, start, land_valid;
  logic [2:0]  new_color_ball;
  logic [11:0] new_color_plats;
  logic [1:0]  land_section;
  logic        color_advance, hit, miss, playing, game_over;
  logic [2:0]  ball_color;
  logic [11:0] plat_colors;
  logic [7:0]  score;
  logic [1:0]  lives;

  int checks = 0;
  int errors = 0;

  color_match_judge #(.SETTLE_CYCLES(SETTLE), .HOLD_CYCLES(HOLD), .LIVES_INIT(3)) dut (
    .clk(clk), .reset(reset), .start(start),
    .new_color_ball(new_color_ball), .new_color_plats(new_color_plats),
    .land_valid(land_valid), .land_section(land_section),
    .color_advance(color_advance), .ball_color(ball_color), .plat_colors(plat_colors),
    .hit(hit), .miss(miss), .score(score), .lives(lives),
    .playing(playing), .game_over(game_over)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  ball;
    logic [11:0] plats;
    logic [1:0]  sec;
    logic        exp_hit;
    logic [7:0]  exp_score;
    logic [1:0]  exp_lives;
    logic        exp_over;
  } vec_t;

  vec_t tbl[7];

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Entered while in LOAD; plays one full round through the result hold.
  task automatic do_round(input vec_t v);
    new_color_ball  = v.ball;
    new_color_plats = v.plats;
    for (int k = 0; k < 20 && !playing; k++) tick();
    check("play_reached", playing, 1);
    check("snap_ball", ball_color, v.ball);
    check("snap_plats", plat_colors, v.plats);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("start_in_play", {playing, color_advance, hit, miss}, 4'b1000);
    land_valid   = 1'b1;
    land_section = v.sec;
    tick();
    land_valid = 1'b0;
    check("hit", hit, v.exp_hit);
    check("miss", miss, !v.exp_hit);
    check("score", score, v.exp_score);
    check("lives", lives, v.exp_lives);
    for (int k = 1; k < HOLD; k++) begin
      tick();
      check("result_hold", {color_advance, hit, miss, playing}, 4'b0000);
    end
    tick();
    check("post_result_adv", color_advance, !v.exp_over);
    check("post_result_over", game_over, v.exp_over);
  endtask

  initial begin
    // plats 12'o1234: sec0=4 sec1=3 sec2=2 sec3=1
    tbl[0] = '{3'd2, 12'o1234, 2'd2, 1'b1, 8'd2, 2'd3, 1'b0};
    tbl[1] = '{3'd4, 12'o1234, 2'd0, 1'b1, 8'd3, 2'd3, 1'b0};
    tbl[2] = '{3'd3, 12'o1234, 2'd1, 1'b1, 8'd4, 2'd3, 1'b0};
    tbl[3] = '{3'd7, 12'o7000, 2'd3, 1'b1, 8'd5, 2'd3, 1'b0};
    tbl[4] = '{3'd1, 12'o1234, 2'd0, 1'b0, 8'd5, 2'd2, 1'b0};
    tbl[5] = '{3'd7, 12'o7000, 2'd0, 1'b0, 8'd5, 2'd1, 1'b0};
    tbl[6] = '{3'd5, 12'o5123, 2'd2, 1'b0, 8'd5, 2'd0, 1'b1};

    reset = 1'b1; start = 1'b0; land_valid = 1'b0; land_section = 2'd0;
    new_color_ball = 3'd2; new_color_plats = 12'o1234;
    tick();
    check("rst_score", score, 0);
    check("rst_lives", lives, 3);
    check("rst_colors", {ball_color, plat_colors}, 0);
    check("rst_flags", {color_advance, hit, miss, playing, game_over}, 0);
    reset = 1'b0;
    land_valid = 1'b1;
    tick(); tick();
    land_valid = 1'b0;
    check("idle_no_action", {color_advance, hit, miss, playing}, 0);

    // Start: single advance pulse, snapshot, PLAY five edges after start.
    start = 1'b1;
    tick();
    start = 1'b0;
    check("start_adv", color_advance, 1);
    for (int k = 1; k < 4; k++) begin
      land_valid = 1'b1;  // ignored in LOAD
      tick();
      check("load_quiet", {color_advance, playing, hit, miss}, 0);
    end
    land_valid = 1'b0;
    tick();
    check("play_at_5", playing, 1);
    check("first_snap", {ball_color, plat_colors}, {3'd2, 12'o1234});
    land_valid = 1'b1; land_section = 2'd2;
    tick();
    land_valid = 1'b0;
    check("first_hit", {hit, miss, score}, {2'b10, 8'd1});
    land_valid = 1'b1;  // ignored in RESULT
    for (int k = 1; k < HOLD; k++) begin
      tick();
      check("first_hold", {color_advance, hit, miss, score}, {3'b000, 8'd1});
    end
    land_valid = 1'b0;
    tick();
    check("first_readv", color_advance, 1);

    foreach (tbl[i]) do_round(tbl[i]);
    check("over_score", score, 5);
    land_valid = 1'b1;
    tick();
    land_valid = 1'b0;
    check("over_quiet", {game_over, hit, miss, lives}, {3'b100, 2'd0});

    // Restart, then unplayable snapshots force a reload.
    start = 1'b1;
    tick();
    start = 1'b0;
    check("restart", {color_advance, game_over, score, lives}, {2'b10, 8'd0, 2'd3});
    new_color_ball = 3'd0; new_color_plats = 12'o1234;
    for (int k = 0; k < 3; k++) tick();
    check("zero_wait", {color_advance, playing}, 2'b00);
    tick();
    check("zero_reload", {color_advance, playing, ball_color}, {2'b10, 3'd0});
    new_color_ball = 3'd5;
    for (int k = 0; k < 4; k++) tick();
    check("nomatch_reload", {color_advance, playing, ball_color}, {2'b10, 3'd5});
    new_color_ball = 3'd1;
    for (int k = 0; k < 4; k++) tick();
    check("match_play", {playing, ball_color}, {1'b1, 3'd1});

    // Reset mid-RESULT clears the in-flight hit immediately.
    land_valid = 1'b1; land_section = 2'd3;
    tick();
    land_valid = 1'b0;
    check("pre_rst_hit", {hit, score}, {1'b1, 8'd1});
    reset = 1'b1;
    #1;
    check("rst_result", {hit, miss, playing, score, lives, ball_color, plat_colors},
          {3'b000, 8'd0, 2'd3, 3'd0, 12'd0});
    tick();
    reset = 1'b0;
    tick();
    check("rst_idle", {color_advance, playing, game_over}, 0);

    // Reset mid-LOAD clears the in-flight advance.
    start = 1'b1;
    tick();
    start = 1'b0;
    check("pre_rst_adv", color_advance, 1);
    reset = 1'b1;
    #1;
    check("rst_load", {color_advance, playing, score, lives}, {2'b00, 8'd0, 2'd3});
    tick();
    reset = 1'b0;

    // Score saturation: 256 consecutive hits.
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 1; i <= 256; i++) begin
      vec_t v;
      v = '{3'd2, 12'o1234, 2'd2, 1'b1, (i > 255) ? 8'd255 : 8'(i), 2'd3, 1'b0};
      do_round(v);
    end
    check("sat_score", score, 255);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
